// File: rtl/serial_subtractor_if.sv
// Operand/result bus for serial_subtractor: one valid/ready channel in, one out.
// A transfer happens on a rising clk edge where valid && ready; the sender holds
// its payload stable while valid is high and ready is low.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bin: DIGIT-bit full-subtractor slices chained through a
// registered borrow, WIDTH/DIGIT cycles per operation.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_subtractor_if.slave    bus,
  output logic [1:0]            dbg_state
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] diff_q;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;
  logic             bout_q;
  logic             ovf_q;
  logic [CW-1:0]    count;
  logic [DIGIT:0]   dig;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0] res_nxt;
  logic             accept;
  logic             last_step;
  logic             in_ready_c;
  logic             out_valid_c;

  // One digit slice: the extra MSB of the difference is the borrow out.
  always_comb begin
    dig     = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};
    res_cat = {dig[DIGIT-1:0], res};
    res_nxt = res_cat[WIDTH+DIGIT-1:DIGIT];
  end

  assign accept    = bus.in_valid && in_ready_c;
  assign last_step = (state == BUSY) && (count == CW'(STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (count == CW'(STEPS - 1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      count  <= '0;
    end else if (accept) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      res    <= '0;
      borrow <= bus.bin;
      a_msb  <= bus.a[WIDTH-1];
      b_msb  <= bus.b[WIDTH-1];
      count  <= '0;
    end else if (state == BUSY) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      res    <= res_nxt;
      borrow <= dig[DIGIT];
      count  <= count + CW'(1);
    end
  end

  // Visible result is latched only on the final slice so it holds through
  // backpressure and after the handshake until the next operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (last_step) begin
      diff_q <= res_nxt;
      bout_q <= dig[DIGIT];
      ovf_q  <= (a_msb ^ b_msb) & (a_msb ^ res_nxt[WIDTH-1]);
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: three instances (8/1, 8/4, 1/1) driven
// through index-selected tasks; index 0 = W8 D1, 1 = W8 D4, 2 = W1 D1.
module tb_serial_subtractor;
  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q[$];

  logic       in_valid_s [3];
  logic       out_ready_s[3];
  logic       bin_s      [3];
  logic [7:0] a_s        [3];
  logic [7:0] b_s        [3];
  logic       in_ready_s [3];
  logic       out_valid_s[3];
  logic       bout_s     [3];
  logic       ovf_s      [3];
  logic [7:0] diff_s     [3];
  logic [1:0] dbg_s      [3];

  serial_subtractor_if #(.WIDTH(8)) bus_d1 ();
  serial_subtractor_if #(.WIDTH(8)) bus_d4 ();
  serial_subtractor_if #(.WIDTH(1)) bus_w1 ();

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(bus_d1), .dbg_state(dbg_s[0]));
  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(bus_d4), .dbg_state(dbg_s[1]));
  serial_subtractor #(.WIDTH(1), .DIGIT(1)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(bus_w1), .dbg_state(dbg_s[2]));

  assign bus_d1.in_valid = in_valid_s[0];
  assign bus_d1.out_ready = out_ready_s[0];
  assign bus_d1.a = a_s[0];
  assign bus_d1.b = b_s[0];
  assign bus_d1.bin = bin_s[0];
  assign in_ready_s[0] = bus_d1.in_ready;
  assign out_valid_s[0] = bus_d1.out_valid;
  assign diff_s[0] = bus_d1.diff;
  assign bout_s[0] = bus_d1.bout;
  assign ovf_s[0] = bus_d1.ovf;

  assign bus_d4.in_valid = in_valid_s[1];
  assign bus_d4.out_ready = out_ready_s[1];
  assign bus_d4.a = a_s[1];
  assign bus_d4.b = b_s[1];
  assign bus_d4.bin = bin_s[1];
  assign in_ready_s[1] = bus_d4.in_ready;
  assign out_valid_s[1] = bus_d4.out_valid;
  assign diff_s[1] = bus_d4.diff;
  assign bout_s[1] = bus_d4.bout;
  assign ovf_s[1] = bus_d4.ovf;

  assign bus_w1.in_valid = in_valid_s[2];
  assign bus_w1.out_ready = out_ready_s[2];
  assign bus_w1.a = a_s[2][0];
  assign bus_w1.b = b_s[2][0];
  assign bus_w1.bin = bin_s[2];
  assign in_ready_s[2] = bus_w1.in_ready;
  assign out_valid_s[2] = bus_w1.out_valid;
  assign diff_s[2] = {7'b0, bus_w1.diff};
  assign bout_s[2] = bus_w1.bout;
  assign ovf_s[2] = bus_w1.ovf;

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input int k, input logic [7:0] av, input logic [7:0] bv, input logic binv);
    int t;
    t = 0;
    while (!in_ready_s[k] && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("in_ready_before_accept", 32'(in_ready_s[k]), 32'd1);
    a_s[k] = av;
    b_s[k] = bv;
    bin_s[k] = binv;
    in_valid_s[k] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[k] = 1'b0;
    chk("busy_after_accept", 32'(dbg_s[k]), 32'd1);
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!out_valid_s[k] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take(input int k);
    out_ready_s[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[k] = 1'b0;
    chk("out_valid_cleared", 32'(out_valid_s[k]), 32'd0);
  endtask

  task automatic run(input int k, input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic binv, input logic [7:0] ed, input logic ebo, input logic eov,
                     input int elat, input bit chk_ov);
    int lat;
    logic [9:0] e;
    exp_q.push_back({ebo, eov, ed});
    start_op(k, av, bv, binv);
    wait_done(k, lat);
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    e = exp_q.pop_front();
    chk({tag, "_diff"}, 32'(diff_s[k]), 32'(e[7:0]));
    chk({tag, "_bout"}, 32'(bout_s[k]), 32'(e[9]));
    if (chk_ov) chk({tag, "_ovf"}, 32'(ovf_s[k]), 32'(e[8]));
    take(k);
  endtask

  initial begin
    logic [7:0] fs_d;
    logic [7:0] fs_bo;
    int lat;
    fs_d  = 8'b1001_0110;  // full-subtractor diff indexed by {a,b,bin}
    fs_bo = 8'b1000_1110;  // full-subtractor borrow indexed by {a,b,bin}
    for (int k = 0; k < 3; k++) begin
      in_valid_s[k] = 1'b0;
      out_ready_s[k] = 1'b0;
      a_s[k] = 8'h00;
      b_s[k] = 8'h00;
      bin_s[k] = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_in_ready", 32'(in_ready_s[k]), 32'd1);
      chk("reset_out_valid", 32'(out_valid_s[k]), 32'd0);
      chk("reset_diff", 32'(diff_s[k]), 32'd0);
      chk("reset_bout_ovf", 32'({bout_s[k], ovf_s[k]}), 32'd0);
    end
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run(2, "w1_truth", {7'b0, v[2]}, {7'b0, v[1]}, v[0], {7'b0, fs_d[i]}, fs_bo[i], 1'b0, 1, 1'b0);
    end

    // WIDTH=8, DIGIT=1
    run(0, "d1_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 8, 1'b1);
    run(0, "d1_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 8, 1'b1);
    run(0, "d1_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 8, 1'b1);
    run(0, "d1_5a_5a_b", 8'h5A, 8'h5A, 1'b1, 8'hFF, 1'b1, 1'b0, 8, 1'b1);

    // WIDTH=8, DIGIT=4
    run(1, "d4_35_17_b", 8'h35, 8'h17, 1'b1, 8'h1D, 1'b0, 1'b0, 2, 1'b1);
    run(1, "d4_00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 2, 1'b1);
    run(1, "d4_7f_80", 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 2, 1'b1);

    // Backpressure in DONE with stray in_valid pulses
    start_op(0, 8'h20, 8'h05, 1'b0);
    wait_done(0, lat);
    chk("bp_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid_s[0]), 32'd1);
      chk("bp_diff", 32'(diff_s[0]), 32'h1B);
      chk("bp_bout_ovf", 32'({bout_s[0], ovf_s[0]}), 32'd0);
      chk("bp_in_ready", 32'(in_ready_s[0]), 32'd0);
      a_s[0] = 8'hFF;
      b_s[0] = 8'h00;
      in_valid_s[0] = (i % 2 == 0);
      @(posedge clk); #1;
    end
    in_valid_s[0] = 1'b0;
    chk("bp_still_done", 32'(dbg_s[0]), 32'd2);
    take(0);
    chk("bp_idle_in_ready", 32'(in_ready_s[0]), 32'd1);
    chk("bp_diff_kept", 32'(diff_s[0]), 32'h1B);
    run(0, "d1_after_bp", 8'h40, 8'h01, 1'b0, 8'h3F, 1'b0, 1'b0, 8, 1'b1);

    // Asynchronous reset in the third BUSY cycle
    start_op(0, 8'hAA, 8'h11, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_busy_diff", 32'(diff_s[0]), 32'd0);
    chk("rst_busy_out_valid", 32'(out_valid_s[0]), 32'd0);
    chk("rst_busy_in_ready", 32'(in_ready_s[0]), 32'd1);
    chk("rst_busy_state", 32'(dbg_s[0]), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run(0, "d1_after_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
